// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and default phase timings for the async SRAM controller.
// Latency: n/a (types and constants only). Backpressure: n/a.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int T_SETUP_DEF = 1;
    localparam int T_PULSE_DEF = 2;
    localparam int T_HOLD_DEF  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter only ever holds T-1, so a T of 2 still fits in one bit.
    function automatic int cnt_width(input int t_max);
        return (t_max <= 2) ? 1 : $clog2(t_max);
    endfunction

endpackage

// File: rtl/sram_phase_cnt.sv
// Phase down-counter: load wins over decrement, stops at zero.
// Latency: count visible one cycle after load/enable. Backpressure: none.
module sram_phase_cnt #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_async_ctrl.sv
// Single-transaction async SRAM controller: SETUP/PULSE/HOLD strobes with a turnaround IDLE.
// Latency: T_SETUP+T_PULSE+T_HOLD cycles per access, plus one IDLE cycle before the next accept.
// Backpressure: req_ready only in IDLE; rsp_valid/wr_done are unconditional one-cycle pulses.
module sram_async_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int T_SETUP    = T_SETUP_DEF,
    parameter int T_PULSE    = T_PULSE_DEF,
    parameter int T_HOLD     = T_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_done,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  cs,
    output logic                  we,
    output logic                  oe
);

    localparam int CW = cnt_width(max3(T_SETUP, T_PULSE, T_HOLD));
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);

    state_t                state;
    logic                  is_wr;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  cnt_load;
    logic [CW-1:0]         cnt_load_val;
    logic [CW-1:0]         cnt;
    logic                  cnt_zero;
    logic                  accept;

    assign accept = req_valid && req_ready;

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = LD_SETUP;
        case (state)
            IDLE:  if (accept)   begin cnt_load = 1'b1; cnt_load_val = LD_SETUP; end
            SETUP: if (cnt_zero) begin cnt_load = 1'b1; cnt_load_val = LD_PULSE; end
            PULSE: if (cnt_zero) begin cnt_load = 1'b1; cnt_load_val = LD_HOLD;  end
            default: ;
        endcase
    end

    sram_phase_cnt #(.WIDTH(CW)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (state != IDLE),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // All strobes are registered and change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            cs        <= 1'b0;
            we        <= 1'b0;
            oe        <= 1'b0;
            drive_en  <= 1'b0;
            is_wr     <= 1'b0;
            wdata_r   <= '0;
            address   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        is_wr     <= req_we;
                        address   <= req_addr;
                        wdata_r   <= req_wdata;
                        cs        <= 1'b1;
                        oe        <= !req_we;
                        drive_en  <= req_we;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state <= PULSE;
                        we    <= is_wr;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        state <= HOLD;
                        we    <= 1'b0;
                        oe    <= 1'b0;
                        if (!is_wr) begin
                            rsp_rdata <= data;
                            rsp_valid <= 1'b1;
                        end else if (T_HOLD == 1) begin
                            wr_done <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Fire one edge early so the pulse lands on the final HOLD cycle.
                    if (is_wr && (cnt == CW'(1))) begin
                        wr_done <= 1'b1;
                    end
                    if (cnt_zero) begin
                        state     <= IDLE;
                        cs        <= 1'b0;
                        drive_en  <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data = drive_en ? wdata_r : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl against an 8x256 async RAM model; a probe drives 0xA5
// onto the bus whenever the controller must be released, so any controller drive corrupts it.
module tb_sram_async_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       wr_done;
    logic [7:0] address;
    wire  [7:0] data;
    logic       cs;
    logic       we;
    logic       oe;

    always #5 clk = ~clk;

    sram_async_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .T_SETUP    (1),
        .T_PULSE    (2),
        .T_HOLD     (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .wr_done   (wr_done),
        .address   (address),
        .data      (data),
        .cs        (cs),
        .we        (we),
        .oe        (oe)
    );

    logic [7:0] mem [0:255];
    logic       cur_write;
    logic       mon_en;
    wire        ram_oe   = cs && oe && !we;
    wire        probe_en = !ram_oe && !(cs && cur_write);

    assign data = ram_oe ? mem[address] : (probe_en ? 8'hA5 : 8'hzz);

    always @(negedge clk) begin
        if (cs && we) mem[address] <= data;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (wr_done)   wr_cnt  <= wr_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Bus protocol checks at every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("we_oe_exclusive", {31'd0, we && oe}, 32'd0);
            if (oe) chk("oe_bus_owned_by_ram", {24'd0, data}, {24'd0, mem[address]});
        end
    end

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] r;
    } vec_t;

    vec_t vecs [6];

    // Expected pins per cycle k after acceptance: 1=SETUP, 2..3=PULSE, 4=HOLD, 5=IDLE.
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] r, output int acc_at);
        logic [5:0] exp_ctrl;
        cur_write = w;
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_at    = cyc;
        req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            exp_ctrl = {k <= 4,                   // cs
                        w && (k == 2 || k == 3),  // we
                        !w && (k <= 3),           // oe
                        k == 5,                   // req_ready
                        !w && (k == 4),           // rsp_valid
                        w && (k == 4)};           // wr_done
            chk($sformatf("ctrl_%s_k%0d", w ? "wr" : "rd", k),
                {26'd0, cs, we, oe, req_ready, rsp_valid, wr_done}, {26'd0, exp_ctrl});
            if (k <= 4) chk($sformatf("address_k%0d", k), {24'd0, address}, {24'd0, a});
            if (w && k <= 4) chk($sformatf("wr_data_k%0d", k), {24'd0, data}, {24'd0, d});
            if (!w && k >= 4) begin
                chk($sformatf("rd_bus_released_k%0d", k), {24'd0, data}, 32'h0000_00A5);
                chk($sformatf("rsp_rdata_k%0d", k), {24'd0, rsp_rdata}, {24'd0, r});
            end
        end
    endtask

    initial begin
        int acc_at;
        int prev_acc;
        int acc0;
        int wr0;
        int rsp0;

        vecs[0] = '{w: 1'b1, a: 8'h10, d: 8'h5A, r: 8'h00};
        vecs[1] = '{w: 1'b0, a: 8'h10, d: 8'h00, r: 8'h5A};
        vecs[2] = '{w: 1'b1, a: 8'h00, d: 8'h01, r: 8'h00};
        vecs[3] = '{w: 1'b1, a: 8'hFF, d: 8'hFF, r: 8'h00};
        vecs[4] = '{w: 1'b0, a: 8'hFF, d: 8'h00, r: 8'hFF};
        vecs[5] = '{w: 1'b0, a: 8'h00, d: 8'h00, r: 8'h01};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        cur_write = 1'b0;
        mon_en    = 1'b0;
        prev_acc  = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {26'd0, cs, we, oe, req_ready, rsp_valid, wr_done}, 32'd0);
        chk("reset_address", {24'd0, address}, 32'd0);
        chk("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset_bus_released", {24'd0, data}, 32'h0000_00A5);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].r, acc_at);
            if (i > 0) chk($sformatf("accept_gap_%0d", i), acc_at - prev_acc, 32'd5);
            prev_acc = acc_at;
        end
        chk("ram_0x10", {24'd0, mem[8'h10]}, 32'h5A);
        chk("ram_0xff", {24'd0, mem[8'hFF]}, 32'hFF);
        chk("rsp_pulses_table", rsp_cnt, 32'd3);
        chk("wr_pulses_table", wr_cnt, 32'd3);

        // req_valid held high: accepts only in IDLE, every fifth edge.
        acc0      = acc_cnt;
        wr0       = wr_cnt;
        cur_write = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h30;
        req_wdata = 8'h33;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("held_ready_%0d", j), {31'd0, req_ready}, {31'd0, (j % 5) == 4});
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_accepts", acc_cnt - acc0, 32'd3);
        chk("held_wr_done", wr_cnt - wr0, 32'd3);
        chk("held_ram_0x30", {24'd0, mem[8'h30]}, 32'h33);

        // Reset during the PULSE of a write aborts it silently.
        wr0       = wr_cnt;
        rsp0      = rsp_cnt;
        cur_write = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_pulse", {29'd0, cs, we, oe}, 32'b110);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {26'd0, cs, we, oe, req_ready, rsp_valid, wr_done}, 32'd0);
        chk("abort_bus_released", {24'd0, data}, 32'h0000_00A5);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("abort_no_wr_done", wr_cnt - wr0, 32'd0);
        chk("abort_no_rsp", rsp_cnt - rsp0, 32'd0);
        chk("abort_idle_ctrl", {29'd0, cs, we, oe}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
